irq_controller: RTL
===================

Name: irq_controller

Overview:
Parametrised interrupt controller that replaces the single-source, hard-wired keyboard interrupt logic in the board top level. It accepts N_SRC interrupt request lines, each configurable as rising-edge (sticky) or level-sensitive, and maskable. It presents the highest-priority pending source to the CPU as a nonzero interrupt_vector, using the existing interrupt_vector/interrupt_ack handshake. Its control and status registers sit on the 64-bit system bus alongside ROM, RAM, UART and keyboard.

Parameters:
N_SRC, 4, number of interrupt sources (1..63); source i reports vector i+1.
VEC_W, 4, interrupt_vector width; N_SRC <= 2**VEC_W - 1 is required (elaboration error otherwise).
BASE, 64'h0000_0000_8000_0020, bus base address of the 32-byte register window.
MODE_RST, all ones, reset value of MODE (1 = edge).
EN_RST, 0, reset value of ENABLE.

Ports:
CLOCK_50  in  1  system clock; all logic on posedge.
KEY0  in  1  asynchronous active-low reset.
irq_src  in  N_SRC  request lines, synchronous to CLOCK_50.
interrupt_vector  out  VEC_W  0 = none, else source index + 1.
interrupt_ack  in  1  CPU acknowledge (level).
irq_any  out  1  OR of (PENDING & ENABLE), registered.
bus_address  in  64  byte address.
bus_write_data  in  64  write data; bits [N_SRC-1:0] used.
bus_write_enable  in  1  write strobe, single cycle per access.
bus_read_enable  in  1  read strobe.
bus_read_data  out  64  read data, registered.

Behaviour:
- Reset (KEY0 low, async): interrupt_vector=0, irq_any=0, bus_read_data=0, PENDING=0, ENABLE=EN_RST, MODE=MODE_RST, FSM=IDLE, edge history=0.
- Register map (offset from BASE, 8-byte aligned):
  - 0x00 PENDING, read-only.
  - 0x08 ENABLE, read/write.
  - 0x10 MODE, read/write.
  - 0x18 CLEAR, write-1-to-clear PENDING edge bits; reads return 0.
  - Upper bits above N_SRC read as 0.
- Bus read: 1-cycle latency. On a cycle with bus_read_enable and the address in the window, bus_read_data takes the register value on the next edge. Otherwise bus_read_data holds its value.
- Bus write: takes effect on the clock edge of the strobe. Addresses outside the window are ignored.
- Edge mode (MODE[i]=1):
  - PENDING[i] is set on the cycle where irq_src[i]=1 and the previous sample was 0.
  - It is cleared by ack of source i or by CLEAR.
  - If a set and a clear happen in the same cycle, the set wins.
- Level mode (MODE[i]=0): PENDING[i] = registered irq_src[i]; ack and CLEAR have no effect.
- Masked sources still latch PENDING; they are only excluded from arbitration.
- Priority: lowest index wins (fixed priority).
- FSM:
  - IDLE: if (PENDING & ENABLE) != 0, latch the winner id and set interrupt_vector=id+1 on the next edge; go to ASSERT.
  - ASSERT: hold the vector. This holds even if the source is later disabled or cleared; there is no retraction. When interrupt_ack=1, set interrupt_vector=0, clear PENDING[id] if id is edge mode, and go to RELEASE.
  - RELEASE: wait for interrupt_ack=0, then go to IDLE.
- The vector is 0 for at least one cycle between consecutive interrupts.
- interrupt_ack in IDLE is ignored.
- Latency: from an edge on irq_src to a nonzero vector is 2 cycles (PENDING register, then vector register).
- Writing a 0 to MODE[i] while PENDING[i]=1 lets PENDING[i] follow the level from the next cycle.
- Reset asserted mid-handshake returns to reset state immediately; a subsequent ack is ignored.

Test Plan:
- Reset, ENABLE=0x1, single pulse on irq_src[0] -> interrupt_vector=1 exactly 2 cycles later; ack=1 -> vector=0 next cycle, PENDING reads 0x0.
- ENABLE=0xF, edges on sources 2 and 1 in the same cycle -> vector=2; after ack/release vector=3; after the second ack PENDING=0.
- Source 3 masked (ENABLE=0x7), edge on source 3 -> vector stays 0, PENDING reads 0x8; write ENABLE=0xF -> vector=4.
- MODE=0x0 (level), hold irq_src[0]=1 through ack -> vector=1 reasserts after RELEASE; drop the line -> PENDING=0 and no further vector.
- Write CLEAR=0x2 in the same cycle as a new edge on source 1 -> PENDING[1] stays 1; a lone CLEAR=0x2 -> PENDING[1]=0.
- Assert KEY0 low while in ASSERT with vector=2 -> vector=0 asynchronously; after release, no vector until a new edge.

Source files
------------

// File: rtl/irq_controller.sv
// Fixed-priority interrupt controller: per-source edge/level capture, mask, CPU vector/ack handshake, 64-bit bus CSRs.
// Latency: irq_src edge -> PENDING 1 cycle -> interrupt_vector 1 cycle; bus reads return one cycle after the strobe.
// Backpressure: a vector is held until interrupt_ack; the next vector waits for ack to drop; the bus never stalls.
module irq_controller #(
    parameter int                 N_SRC    = 4,
    parameter int                 VEC_W    = 4,
    parameter logic [63:0]        BASE     = 64'h0000_0000_8000_0020,
    parameter logic [N_SRC-1:0]   MODE_RST = '1,
    parameter logic [N_SRC-1:0]   EN_RST   = '0
) (
    input  logic               CLOCK_50,
    input  logic               KEY0,
    input  logic [N_SRC-1:0]   irq_src,
    output logic [VEC_W-1:0]   interrupt_vector,
    input  logic               interrupt_ack,
    output logic               irq_any,
    input  logic [63:0]        bus_address,
    input  logic [63:0]        bus_write_data,
    input  logic               bus_write_enable,
    input  logic               bus_read_enable,
    output logic [63:0]        bus_read_data
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ASSERT  = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    localparam logic [1:0] SEL_PEND  = 2'd0;
    localparam logic [1:0] SEL_EN    = 2'd1;
    localparam logic [1:0] SEL_MODE  = 2'd2;
    localparam logic [1:0] SEL_CLR   = 2'd3;

    generate
        if ((N_SRC < 1) || (N_SRC > 63) || (N_SRC > (2**VEC_W) - 1)) begin : g_param_check
            $error("irq_controller: N_SRC must be 1..63 and fit in VEC_W bits as index+1");
        end
    endgenerate

    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] en_q, en_d;
    logic [N_SRC-1:0] mode_q, mode_d;
    logic [N_SRC-1:0] prev_q, prev_d;
    logic [1:0]       state_q, state_d;
    logic [VEC_W-1:0] id_q, id_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic             any_q, any_d;
    logic [63:0]      rdata_q, rdata_d;

    logic [63:0]      off;
    logic             in_win;
    logic [1:0]       sel;
    logic             wr_hit;
    logic             rd_hit;
    logic [N_SRC-1:0] wdat;
    logic [N_SRC-1:0] clr_wr;
    logic [N_SRC-1:0] ack_clr;
    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] edge_set;
    logic [VEC_W-1:0] win_id;
    logic             unused_bits;

    // Unsigned wrap makes addresses below BASE land far outside the window.
    assign off    = bus_address - BASE;
    assign in_win = (off[63:5] == '0);
    assign sel    = off[4:3];
    assign wr_hit = bus_write_enable & in_win;
    assign rd_hit = bus_read_enable & in_win;
    assign wdat   = bus_write_data[N_SRC-1:0];
    assign clr_wr = (wr_hit && (sel == SEL_CLR)) ? wdat : '0;

    assign unused_bits = ^{off[2:0], bus_write_data[63:N_SRC]};

    assign req      = pend_q & en_q;
    assign edge_set = irq_src & ~prev_q;

    // Descending scan so the lowest requesting index is the last assignment.
    always_comb begin
        win_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_id = VEC_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        vec_d   = vec_q;
        ack_clr = '0;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    id_d    = win_id;
                    vec_d   = win_id + VEC_W'(1);
                    state_d = S_ASSERT;
                end
            end
            S_ASSERT: begin
                if (interrupt_ack) begin
                    vec_d   = '0;
                    ack_clr = N_SRC'(1) << id_q;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!interrupt_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                vec_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Edge bits: a new edge beats any clear in the same cycle. Level bits track the line.
    always_comb begin
        pend_d = (mode_q & (edge_set | (pend_q & ~(clr_wr | ack_clr))))
               | (~mode_q & irq_src);
        prev_d = irq_src;
        any_d  = |req;
    end

    always_comb begin
        en_d    = en_q;
        mode_d  = mode_q;
        rdata_d = rdata_q;
        if (wr_hit && (sel == SEL_EN)) begin
            en_d = wdat;
        end
        if (wr_hit && (sel == SEL_MODE)) begin
            mode_d = wdat;
        end
        if (rd_hit) begin
            case (sel)
                SEL_PEND: rdata_d = 64'(pend_q);
                SEL_EN:   rdata_d = 64'(en_q);
                SEL_MODE: rdata_d = 64'(mode_q);
                default:  rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            pend_q  <= '0;
            en_q    <= EN_RST;
            mode_q  <= MODE_RST;
            prev_q  <= '0;
            state_q <= S_IDLE;
            id_q    <= '0;
            vec_q   <= '0;
            any_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            pend_q  <= pend_d;
            en_q    <= en_d;
            mode_q  <= mode_d;
            prev_q  <= prev_d;
            state_q <= state_d;
            id_q    <= id_d;
            vec_q   <= vec_d;
            any_q   <= any_d;
            rdata_q <= rdata_d;
        end
    end

    assign interrupt_vector = vec_q;
    assign irq_any          = any_q;
    assign bus_read_data    = rdata_q;

endmodule
